prog_mem: RTL

Parametrised, loadable program memory that replaces the fixed combinational instruction ROM in front of the CPU fetch stage. Storage is byte-wide; a fetch assembles one instruction word of WORD_BYTES consecutive bytes, little-endian, reading one byte per clock. A byte-write load port lets a testbench or boot loader fill the memory before and between runs. Fetch uses a request/ready/valid handshake so the fetch stage stalls on multi-cycle reads.

---
 rtl/prog_mem_if.sv | 38 +++
 rtl/prog_mem.sv | 118 +++++++++++
 2 files changed

// File: rtl/prog_mem_if.sv
// prog_mem_if: load and fetch bus of the program memory.
//   load_en/load_addr/load_data : byte write port (master -> memory)
//   fetch_req/fetch_addr        : word fetch request (master -> memory)
//   fetch_ready                 : memory idle, will accept a request
//   fetch_valid                 : one-cycle pulse, fetch_data/fetch_err valid
//   fetch_data                  : assembled little-endian word
//   fetch_err                   : some byte of the word lay outside DEPTH
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

interface prog_mem_if #(
    parameter int ADDR_SIZE  = `ADDR_SIZE,
    parameter int BYTE_SIZE  = 8,
    parameter int WORD_BYTES = `WORD_SIZE / BYTE_SIZE
);
    logic                              load_en;
    logic [ADDR_SIZE-1:0]              load_addr;
    logic [BYTE_SIZE-1:0]              load_data;
    logic                              fetch_req;
    logic [ADDR_SIZE-1:0]              fetch_addr;
    logic                              fetch_ready;
    logic                              fetch_valid;
    logic [WORD_BYTES*BYTE_SIZE-1:0]   fetch_data;
    logic                              fetch_err;

    modport master (
        output load_en, load_addr, load_data, fetch_req, fetch_addr,
        input  fetch_ready, fetch_valid, fetch_data, fetch_err
    );
    modport slave (
        input  load_en, load_addr, load_data, fetch_req, fetch_addr,
        output fetch_ready, fetch_valid, fetch_data, fetch_err
    );
endinterface

// File: rtl/prog_mem.sv
// prog_mem: loadable byte-wide program memory. A fetch assembles WORD_BYTES
// consecutive bytes (little-endian) reading one byte per clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (also clears all stored bytes)
//   bus   : prog_mem_if slave (load port + fetch handshake)
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module prog_mem #(
    parameter int ADDR_SIZE  = `ADDR_SIZE,
    parameter int BYTE_SIZE  = 8,
    parameter int WORD_BYTES = `WORD_SIZE / BYTE_SIZE,
    parameter int DEPTH      = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    prog_mem_if.slave  bus
);
    localparam int CW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORD_BYTES - 1);

    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

    state_t                                  state_q, state_d;
    logic [ADDR_SIZE-1:0]                    base_q, base_d;
    logic [CW-1:0]                           cnt_q, cnt_d;
    logic                                    err_q, err_d;
    logic [WORD_BYTES-1:0][BYTE_SIZE-1:0]    asm_q, asm_d;
    logic [WORD_BYTES*BYTE_SIZE-1:0]         data_q, data_d;
    logic                                    ferr_q, ferr_d;

    logic [BYTE_SIZE-1:0] mem_q [DEPTH];

    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 rd_in;
    logic [BYTE_SIZE-1:0] rd_byte;
    logic                 wr_in;

    // Address arithmetic wraps naturally at ADDR_SIZE bits.
    assign rd_addr = base_q + ADDR_SIZE'(cnt_q);
    assign rd_in   = (32'(rd_addr) < 32'(DEPTH));
    assign rd_byte = rd_in ? mem_q[rd_addr[IW-1:0]] : '0;
    assign wr_in   = (32'(bus.load_addr) < 32'(DEPTH));

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        asm_d   = asm_q;
        data_d  = data_q;
        ferr_d  = ferr_q;
        case (state_q)
            IDLE: begin
                if (bus.fetch_req) begin
                    base_d  = bus.fetch_addr;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = READ;
                end
            end
            READ: begin
                asm_d[cnt_q] = rd_byte;
                if (!rd_in) err_d = 1'b1;
                if (cnt_q == LAST) begin
                    // Publish on DONE entry, including the byte read this cycle.
                    data_d  = asm_d;
                    ferr_d  = err_d;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            asm_q   <= '0;
            data_q  <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            asm_q   <= asm_d;
            data_q  <= data_d;
            ferr_q  <= ferr_d;
        end
    end

    // Write lands at the edge, so a same-cycle read sees the old byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (bus.load_en && wr_in) begin
            mem_q[bus.load_addr[IW-1:0]] <= bus.load_data;
        end
    end

    assign bus.fetch_ready = (state_q == IDLE);
    assign bus.fetch_valid = (state_q == DONE);
    assign bus.fetch_data  = data_q;
    assign bus.fetch_err   = ferr_q;

endmodule
